seven_seg_scan_decoder: RTL and testbench

//  Receive-side counterpart of the multiplexed 7-segment display driver. Samples the

---
 rtl/seven_seg_scan_decoder.sv | 192 +++++++++++++++++++
 tb/tb_seven_seg_scan_decoder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_decoder
//
// Purpose:
//   Receive side of a multiplexed 7-segment display. The scanned segment and
//   digit-select pins are synchronized and polarity-corrected. A glitch filter
//   requires STABLE_CYCLES identical samples before a digit is captured. Each
//   captured segment pattern is decoded back to BCD, and digits are assembled
//   into complete frames.
//
// Ports:
//   clk           in   system clock (single domain)
//   rst           in   synchronous active-high reset
//   en            in   1: decode; 0: freeze outputs, clear filter, no captures
//   seg_in        in   [6:0] segments {g,f,e,d,c,b,a}, asynchronous pins
//   digit_sel_in  in   [NUM_DIGITS-1:0] one-hot digit select, bit0 = LSD
//   bcd_out       out  [4*NUM_DIGITS-1:0] last complete frame, digit i at [4i+3:4i]
//   frame_valid   out  one-cycle pulse when bcd_out/frame_err update
//   frame_err     out  published frame contained an undecodable digit
//   signal_lost   out  no capture for TIMEOUT_CYCLES cycles
// ---------------------------------------------------------------------------
module seven_seg_scan_decoder #(
    parameter int NUM_DIGITS     = 3,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SEG_ACT_LOW    = 0,
    parameter int SEL_ACT_LOW    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_sel_in,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic                    signal_lost
);

    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int S_W   = NUM_DIGITS + 7;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic {
        SETTLE = 1'b0,
        HOLD   = 1'b1
    } state_t;

    // Returns {err, code}. Blank (all segments off) decodes to F without error.
    // Alternate 6/7/9 glyphs (with or without the extra tail segment) are accepted.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h3F:        r = {1'b0, 4'd0};
            7'h06:        r = {1'b0, 4'd1};
            7'h5B:        r = {1'b0, 4'd2};
            7'h4F:        r = {1'b0, 4'd3};
            7'h66:        r = {1'b0, 4'd4};
            7'h6D:        r = {1'b0, 4'd5};
            7'h7D, 7'h7C: r = {1'b0, 4'd6};
            7'h07, 7'h27: r = {1'b0, 4'd7};
            7'h7F:        r = {1'b0, 4'd8};
            7'h6F, 7'h67: r = {1'b0, 4'd9};
            7'h00:        r = {1'b0, 4'hF};
            default:      r = {1'b1, 4'hE};
        endcase
        return r;
    endfunction

    logic [6:0]              seg_p0, seg_p1;
    logic [NUM_DIGITS-1:0]   sel_p0, sel_p1;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   sel;
    logic [S_W-1:0]          sample, prev_p2;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    same, onehot, capture, complete;
    logic [4:0]              dec;
    logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt;
    logic [NUM_DIGITS-1:0]   seen, seen_nxt;
    logic                    err, err_nxt;
    logic [TO_W-1:0]         tcnt, tcnt_nxt;
    state_t                  state, state_nxt;

    // Stage p1 output: synchronized pins, polarity corrected
    assign seg    = (SEG_ACT_LOW != 0) ? ~seg_p1 : seg_p1;
    assign sel    = (SEL_ACT_LOW != 0) ? ~sel_p1 : sel_p1;
    assign sample = {sel, seg};

    always_comb begin
        same    = (sample == prev_p2);
        onehot  = $onehot(sel);
        dec     = decode_seg(seg);
        cnt_nxt = '0;
        if (same) begin
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
        // cnt_nxt reaching the maximum means STABLE_CYCLES identical samples,
        // including the current one, so the capture lands on this edge.
        capture = en && (state == SETTLE) && onehot && (cnt_nxt == CNT_MAX);

        state_nxt = state;
        if (!en) begin
            state_nxt = SETTLE;
        end else begin
            case (state)
                SETTLE:  if (capture) state_nxt = HOLD;
                HOLD:    if (!same) state_nxt = SETTLE;
                default: state_nxt = SETTLE;
            endcase
        end

        shadow_nxt = shadow;
        seen_nxt   = seen;
        err_nxt    = err;
        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel[i]) shadow_nxt[4*i +: 4] = dec[3:0];
            end
            seen_nxt = seen | sel;
            err_nxt  = err | dec[4];
        end
        complete = capture && (&seen_nxt);

        tcnt_nxt = tcnt;
        if (capture) begin
            tcnt_nxt = '0;
        end else if (en && (tcnt != TO_MAX)) begin
            tcnt_nxt = tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SETTLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage p0/p1: two-flop synchronizer; stage p2: filter and frame assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_p0      <= '0;
            seg_p1      <= '0;
            sel_p0      <= '0;
            sel_p1      <= '0;
            prev_p2     <= '0;
            cnt         <= '0;
            seen        <= '0;
            err         <= 1'b0;
            tcnt        <= '0;
            bcd_out     <= '1;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            seg_p0      <= seg_in;
            seg_p1      <= seg_p0;
            sel_p0      <= digit_sel_in;
            sel_p1      <= sel_p0;
            prev_p2     <= sample;
            cnt         <= en ? cnt_nxt : '0;
            tcnt        <= tcnt_nxt;
            frame_valid <= complete;
            if (complete) begin
                bcd_out   <= shadow_nxt;
                frame_err <= err_nxt;
                seen      <= '0;
                err       <= 1'b0;
            end else begin
                seen <= seen_nxt;
                err  <= err_nxt;
            end
            // Kept as a flag rather than decoded from tcnt so that it reads as
            // lost straight out of reset, before any digit has been seen.
            if (capture) begin
                signal_lost <= 1'b0;
            end else if (tcnt_nxt == TO_MAX) begin
                signal_lost <= 1'b1;
            end
        end
    end

    // Digit values are pure data; stale entries are masked by the seen bits.
    always_ff @(posedge clk) begin
        shadow <= shadow_nxt;
    end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_decoder
//
// Purpose:
//   Self-checking bench for seven_seg_scan_decoder. The stimulus is a series
//   of pin "steps" (value held for N cycles). The reference model predicts
//   captures from run lengths and assembles expected frames. Every observed
//   frame_valid pulse is compared with the next expected frame.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_decoder;

    localparam int ND = 3;
    localparam int ST = 4;
    localparam int TO = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [6:0]    seg_in = '0;
    logic [ND-1:0] digit_sel_in = '0;
    logic [4*ND-1:0] bcd_out;
    logic          frame_valid, frame_err, signal_lost;

    seven_seg_scan_decoder #(
        .NUM_DIGITS(ND), .STABLE_CYCLES(ST), .TIMEOUT_CYCLES(TO),
        .SEG_ACT_LOW(0), .SEL_ACT_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .seg_in(seg_in),
        .digit_sel_in(digit_sel_in), .bcd_out(bcd_out),
        .frame_valid(frame_valid), .frame_err(frame_err),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int frames_seen = 0;
    int frames_expected = 0;

    logic [11:0] exp_bcd_q[$];
    logic        exp_err_q[$];
    logic [3:0]  m_shadow[ND];
    bit          m_seen[ND];
    bit          m_err;
    logic [11:0] last_bcd = 12'hFFF;
    logic [9:0]  last_pins = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Digit value shown by a segment pattern; bit4 flags an unreadable glyph.
    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        case (s)
            7'h3F: return 5'h00;
            7'h06: return 5'h01;
            7'h5B: return 5'h02;
            7'h4F: return 5'h03;
            7'h66: return 5'h04;
            7'h6D: return 5'h05;
            7'h7D, 7'h7C: return 5'h06;
            7'h07, 7'h27: return 5'h07;
            7'h7F: return 5'h08;
            7'h6F, 7'h67: return 5'h09;
            7'h00: return 5'h0F;
            default: return 5'h1E;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ND; i++) m_seen[i] = 0;
        m_err = 0;
    endtask

    task automatic model_capture(input logic [2:0] sel, input logic [6:0] seg);
        logic [4:0]  d;
        logic [11:0] f;
        int          idx;
        bit          all;
        idx = (sel == 3'b001) ? 0 : (sel == 3'b010) ? 1 : 2;
        d = ref_decode(seg);
        m_shadow[idx] = d[3:0];
        m_seen[idx]   = 1;
        m_err         = m_err | d[4];
        all = 1;
        for (int i = 0; i < ND; i++) all = all & m_seen[i];
        if (all) begin
            f = {m_shadow[2], m_shadow[1], m_shadow[0]};
            exp_bcd_q.push_back(f);
            exp_err_q.push_back(m_err);
            last_bcd = f;
            frames_expected++;
            model_clear();
        end
    endtask

    task automatic tick();
        logic [11:0] b;
        logic        e;
        @(posedge clk);
        #1;
        if (frame_valid === 1'b1) begin
            frames_seen++;
            if (exp_bcd_q.size() == 0) begin
                check("unexpected_frame_valid", 32'(frame_valid), 0);
            end else begin
                b = exp_bcd_q.pop_front();
                e = exp_err_q.pop_front();
                check("frame_bcd", 32'(bcd_out), 32'(b));
                check("frame_err", 32'(frame_err), 32'(e));
            end
        end
    endtask

    // Hold pins for len cycles; a one-hot run of at least ST cycles is one capture.
    task automatic step(input logic [2:0] sel, input logic [6:0] seg, input int len);
        bit oh;
        oh = (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
        digit_sel_in = sel;
        seg_in       = seg;
        if (({sel, seg} != last_pins) && (len >= ST) && oh) model_capture(sel, seg);
        last_pins = {sel, seg};
        repeat (len) tick();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        digit_sel_in = '0;
        seg_in = '0;
        tick();
        rst = 1'b0;
        model_clear();
        last_pins = '0;
        last_bcd  = 12'hFFF;
    endtask

    logic [2:0] sel_tab[5] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b011};
    logic [6:0] seg_tab[12] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                7'h7C, 7'h27, 7'h7F, 7'h67, 7'h00, 7'h49};

    initial begin
        logic [2:0] rs;
        logic [6:0] rg;
        int         rl;

        reset_dut();
        check("rst_bcd", 32'(bcd_out), 32'hFFF);
        check("rst_frame_valid", 32'(frame_valid), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_signal_lost", 32'(signal_lost), 1);
        en = 1'b1;

        // Basic scan 1,2,3
        step(3'b001, 7'h06, 8);
        step(3'b010, 7'h5B, 8);
        step(3'b100, 7'h4F, 8);
        step(3'b000, 7'h00, 8);
        check("scan_bcd", 32'(bcd_out), 32'h321);
        check("scan_err", 32'(frame_err), 0);
        check("scan_one_pulse", frames_seen, 1);
        check("scan_lost", 32'(signal_lost), 0);

        // Short glitch is not captured; a long hold captures exactly once
        step(3'b001, 7'h3F, 8);
        step(3'b100, 7'h4F, 8);
        step(3'b010, 7'h06, 3);
        step(3'b010, 7'h5B, 10);
        step(3'b000, 7'h00, 8);
        check("glitch_bcd", 32'(bcd_out), 32'h320);
        check("glitch_pulses", frames_seen, 2);

        // Undecodable digit sets frame_err; next clean frame clears it
        step(3'b001, 7'h06, 8);
        step(3'b010, 7'h5B, 8);
        step(3'b100, 7'h49, 8);
        step(3'b000, 7'h00, 8);
        check("bad_bcd", 32'(bcd_out), 32'hE21);
        check("bad_err", 32'(frame_err), 1);
        step(3'b001, 7'h3F, 8);
        step(3'b010, 7'h06, 8);
        step(3'b100, 7'h5B, 8);
        step(3'b000, 7'h00, 8);
        check("clean_bcd", 32'(bcd_out), 32'h210);
        check("clean_err", 32'(frame_err), 0);

        // Multi-hot and blank selects never capture; blank segments decode to F
        step(3'b011, 7'h06, 20);
        step(3'b000, 7'h06, 20);
        step(3'b001, 7'h00, 8);
        step(3'b010, 7'h06, 8);
        step(3'b100, 7'h5B, 8);
        step(3'b000, 7'h00, 8);
        check("blank_bcd", 32'(bcd_out), 32'h21F);
        check("blank_err", 32'(frame_err), 0);

        // Random steps against the model
        for (int k = 0; k < 60; k++) begin
            do begin
                rs = sel_tab[$urandom_range(0, 4)];
                rg = ($urandom_range(0, 5) == 0) ? 7'($urandom) : seg_tab[$urandom_range(0, 11)];
            end while ({rs, rg} == last_pins);
            rl = $urandom_range(2, 10);
            step(rs, rg, rl);
        end
        step(3'b000, 7'h00, 8);
        check("random_last_bcd", 32'(bcd_out), 32'(last_bcd));

        // Timeout: nothing captured for long enough -> signal_lost
        repeat (4000) tick();
        check("before_timeout_lost", 32'(signal_lost), 0);
        repeat (200) tick();
        check("timeout_lost", 32'(signal_lost), 1);
        check("timeout_bcd_kept", 32'(bcd_out), 32'(last_bcd));
        digit_sel_in = 3'b001;
        seg_in = 7'h06;
        model_capture(3'b001, 7'h06);
        last_pins = {3'b001, 7'h06};
        repeat (5) tick();
        check("lost_before_capture", 32'(signal_lost), 1);
        tick();
        check("lost_after_capture", 32'(signal_lost), 0);
        repeat (2) tick();
        step(3'b010, 7'h6D, 8);
        step(3'b100, 7'h66, 8);
        step(3'b000, 7'h00, 8);
        check("after_lost_bcd", 32'(bcd_out), 32'h451);

        // en low mid-frame: no capture, state kept; frame completes afterwards
        step(3'b001, 7'h66, 8);
        step(3'b010, 7'h6D, 8);
        en = 1'b0;
        digit_sel_in = 3'b100;
        seg_in = 7'h7D;
        last_pins = {3'b100, 7'h7D};
        repeat (50) tick();
        check("en_low_bcd", 32'(bcd_out), 32'h451);
        check("en_low_frame_valid", 32'(frame_valid), 0);
        en = 1'b1;
        model_capture(3'b100, 7'h7D);
        repeat (10) tick();
        step(3'b000, 7'h00, 8);
        check("en_resume_bcd", 32'(bcd_out), 32'h654);

        // Reset mid-frame discards the partial frame
        step(3'b001, 7'h07, 8);
        step(3'b010, 7'h7F, 8);
        step(3'b000, 7'h00, 8);
        reset_dut();
        check("midrst_bcd", 32'(bcd_out), 32'hFFF);
        check("midrst_lost", 32'(signal_lost), 1);
        check("midrst_err", 32'(frame_err), 0);
        step(3'b100, 7'h6F, 8);
        step(3'b000, 7'h00, 8);
        check("midrst_no_frame", 32'(bcd_out), 32'hFFF);
        step(3'b001, 7'h7C, 8);
        step(3'b010, 7'h27, 8);
        step(3'b000, 7'h00, 8);
        check("midrst_new_frame", 32'(bcd_out), 32'h976);

        check("pending_frames", exp_bcd_q.size(), 0);
        check("frame_count", frames_seen, frames_expected);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
